// File: rtl/sand_pkg.sv
// Shared types and helpers for the sandpile grid engine.
// Holds the engine state encoding, the drop-request record and height saturation.
package sand_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STABLE = 2'd1,
    DROP   = 2'd2,
    TOPPLE = 2'd3
  } eng_state_e;

  localparam int COORD_W = 9;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } drop_t;

  // Clamp a signed intermediate height into [0, max_h].
  function automatic int sat_height(input int value, input int max_h);
    if (value > max_h) return max_h;
    if (value < 0) return 0;
    return value;
  endfunction

endpackage

// File: rtl/sand_cell_v3.sv
// One sandpile cell: height register plus the "at or above threshold" flag.
// Priority inside the cell: clear, preload, then topple update or single-grain add.
module sand_cell_v3
  import sand_pkg::*;
#(
  parameter int HEIGHT_W  = 4,
  parameter int THRESHOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                active,
  input  logic                topple_en,
  input  logic                add_grain,
  input  logic                load,
  input  logic [HEIGHT_W-1:0] load_data,
  input  logic [3:0]          nbr_topple,
  output logic [HEIGHT_W-1:0] height,
  output logic                over
);

  localparam int MAX_H = 2**HEIGHT_W - 1;

  int topple_val;

  assign over = int'(height) >= THRESHOLD;

  always_comb begin
    topple_val = int'(height) - (over ? 4 : 0) + int'($countones(nbr_topple));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      height <= '0;
    end else if (clear) begin
      height <= '0;
    end else if (load) begin
      height <= load_data;
    end else if (active) begin
      if (topple_en)
        height <= HEIGHT_W'(sat_height(topple_val, MAX_H));
      else if (add_grain)
        height <= HEIGHT_W'(sat_height(int'(height) + 1, MAX_H));
    end
  end

endmodule

// File: rtl/sand_grid_engine.sv
// Abelian-sandpile grid: cell array with window/border wiring, drop FIFO,
// stability FSM, avalanche counter and registered readout port.
module sand_grid_engine
  import sand_pkg::*;
#(
  parameter int ROWS        = 5,
  parameter int COLS        = 5,
  parameter int HEIGHT_W    = 4,
  parameter int THRESHOLD   = 4,
  parameter int BORDER_WRAP = 0,
  parameter int DROP_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_i,
  input  logic                         clear_i,
  input  logic [$clog2(ROWS+1)-1:0]    rows_i,
  input  logic [$clog2(COLS+1)-1:0]    cols_i,
  input  logic                         drop_valid_i,
  output logic                         drop_ready_o,
  input  logic [COORD_W-1:0]           drop_x_i,
  input  logic [COORD_W-1:0]           drop_y_i,
  output logic                         drop_err_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(ROWS*COLS)-1:0] addr_i,
  input  logic [HEIGHT_W-1:0]          wr_data_i,
  output logic [HEIGHT_W-1:0]          rd_data_o,
  output logic [ROWS*COLS-1:0]         collapse_o,
  output logic                         stable_o,
  output logic [CNT_W-1:0]             aval_cnt_o,
  output logic                         busy_o
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(DROP_DEPTH);

  if ((2**HEIGHT_W - 1 < THRESHOLD + 4) || (THRESHOLD < 4) ||
      (DROP_DEPTH < 2) || (2**PW != DROP_DEPTH)) begin : g_param_check
    $error("sand_grid_engine: illegal HEIGHT_W/THRESHOLD/DROP_DEPTH combination");
  end

  eng_state_e          state;
  logic [CNT_W-1:0]    topple_cnt;
  int                  rows_eff, cols_eff;
  logic [HEIGHT_W-1:0] h [N];
  logic [N-1:0]        over, active, unst;
  logic [3:0]          nbr [N];
  logic                any_unst, topple_en, drop_fire, load_en;

  drop_t               fifo_mem [DROP_DEPTH];
  logic [PW:0]         wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full, drop_acc, in_win, push;
  drop_t               head;
  int                  head_idx;
  logic [HEIGHT_W-1:0] target_h, rd_next;
  logic                target_act;

  always_comb begin
    rows_eff = (rows_i == '0 || int'(rows_i) > ROWS) ? ROWS : int'(rows_i);
    cols_eff = (cols_i == '0 || int'(cols_i) > COLS) ? COLS : int'(cols_i);
  end

  assign unst      = over & active;
  assign any_unst  = |unst;
  assign topple_en = (state == TOPPLE) && run_i && !clear_i;
  assign drop_fire = (state == DROP) && run_i && !clear_i && !fifo_empty;
  assign load_en   = (state == IDLE) && wr_en_i && !clear_i;

  // Edge cells in wrap mode look across the live window, not the physical grid.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        nbr[r*COLS+c] = '0;
        if (r > 0)                 nbr[r*COLS+c][0] = unst[(r-1)*COLS+c];
        else if (BORDER_WRAP != 0) nbr[r*COLS+c][0] = unst[(rows_eff-1)*COLS+c];
        if (r + 1 < rows_eff)      nbr[r*COLS+c][1] = unst[(r+1)*COLS+c];
        else if (BORDER_WRAP != 0) nbr[r*COLS+c][1] = unst[c];
        if (c > 0)                 nbr[r*COLS+c][2] = unst[r*COLS+c-1];
        else if (BORDER_WRAP != 0) nbr[r*COLS+c][2] = unst[r*COLS+cols_eff-1];
        if (c + 1 < cols_eff)      nbr[r*COLS+c][3] = unst[r*COLS+c+1];
        else if (BORDER_WRAP != 0) nbr[r*COLS+c][3] = unst[r*COLS];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int I = r*COLS + c;
      assign active[I] = (r < rows_eff) && (c < cols_eff);
      sand_cell_v3 #(
        .HEIGHT_W  (HEIGHT_W),
        .THRESHOLD (THRESHOLD)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_i),
        .active     (active[I]),
        .topple_en  (topple_en),
        .add_grain  (drop_fire && (head_idx == I)),
        .load       (load_en && (int'(addr_i) == I)),
        .load_data  (wr_data_i),
        .nbr_topple (nbr[I]),
        .height     (h[I]),
        .over       (over[I])
      );
    end
  end

  assign collapse_o = over;
  assign stable_o   = !any_unst && fifo_empty;
  assign busy_o     = (state == DROP) || (state == TOPPLE);

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign drop_ready_o = !fifo_full && !clear_i;
  assign drop_acc     = drop_valid_i && drop_ready_o;
  assign in_win       = (int'(drop_x_i) < cols_eff) && (int'(drop_y_i) < rows_eff);
  assign push         = drop_acc && in_win;
  assign head         = fifo_mem[rd_ptr[PW-1:0]];
  assign head_idx     = int'(head.y) * COLS + int'(head.x);

  always_comb begin
    target_h   = '0;
    target_act = 1'b0;
    rd_next    = '0;
    for (int i = 0; i < N; i++) begin
      if (i == head_idx) begin
        target_h   = h[i];
        target_act = active[i];
      end
      if (i == int'(addr_i)) rd_next = h[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= '{x: drop_x_i, y: drop_y_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_err_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_data_o <= rd_next;
      if (clear_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        drop_err_o <= 1'b0;
      end else begin
        if (push)      wr_ptr <= wr_ptr + 1'b1;
        if (drop_fire) rd_ptr <= rd_ptr + 1'b1;
        drop_err_o <= drop_acc && !in_win;
      end
    end
  end

  // topple_cnt survives a run_i pause so a resumed avalanche keeps counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      topple_cnt <= '0;
      aval_cnt_o <= '0;
    end else if (clear_i) begin
      state      <= run_i ? STABLE : IDLE;
      topple_cnt <= '0;
      aval_cnt_o <= '0;
    end else if (!run_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= STABLE;
        STABLE: begin
          if (any_unst)         state <= TOPPLE;
          else if (!fifo_empty) state <= DROP;
        end
        DROP: begin
          if (!fifo_empty && target_act && (int'(target_h) + 1 >= THRESHOLD))
            state <= TOPPLE;
          else
            state <= STABLE;
        end
        TOPPLE: begin
          if (any_unst) begin
            if (topple_cnt != '1) topple_cnt <= topple_cnt + 1'b1;
          end else begin
            state      <= STABLE;
            aval_cnt_o <= topple_cnt;
            topple_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sand_grid_engine.sv
// Directed bench for sand_grid_engine: one open-border and one wrap-border instance
// share all inputs; expected heights and pulses are hand-computed.
module tb_sand_grid_engine;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int HW   = 4;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst, run_i, clear_i, drop_valid_i, wr_en_i;
  logic [2:0]    rows_i, cols_i;
  logic [8:0]    drop_x_i, drop_y_i;
  logic [4:0]    addr_i;
  logic [HW-1:0] wr_data_i;

  logic          ready_o, err_o, stable_o, busy_o;
  logic [HW-1:0] rd_o;
  logic [24:0]   coll_o;
  logic [CW-1:0] aval_o;
  logic          ready_w, err_w, stable_w, busy_w;
  logic [HW-1:0] rd_w;
  logic [24:0]   coll_w;
  logic [CW-1:0] aval_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sand_grid_engine #(.ROWS(ROWS), .COLS(COLS), .HEIGHT_W(HW), .THRESHOLD(4),
                     .BORDER_WRAP(0), .DROP_DEPTH(4), .CNT_W(CW)) u_open (
    .clk(clk), .rst(rst), .run_i(run_i), .clear_i(clear_i), .rows_i(rows_i), .cols_i(cols_i),
    .drop_valid_i(drop_valid_i), .drop_ready_o(ready_o), .drop_x_i(drop_x_i), .drop_y_i(drop_y_i),
    .drop_err_o(err_o), .wr_en_i(wr_en_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .rd_data_o(rd_o), .collapse_o(coll_o), .stable_o(stable_o), .aval_cnt_o(aval_o), .busy_o(busy_o));

  sand_grid_engine #(.ROWS(ROWS), .COLS(COLS), .HEIGHT_W(HW), .THRESHOLD(4),
                     .BORDER_WRAP(1), .DROP_DEPTH(4), .CNT_W(CW)) u_wrap (
    .clk(clk), .rst(rst), .run_i(run_i), .clear_i(clear_i), .rows_i(rows_i), .cols_i(cols_i),
    .drop_valid_i(drop_valid_i), .drop_ready_o(ready_w), .drop_x_i(drop_x_i), .drop_y_i(drop_y_i),
    .drop_err_o(err_w), .wr_en_i(wr_en_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .rd_data_o(rd_w), .collapse_o(coll_w), .stable_o(stable_w), .aval_cnt_o(aval_w), .busy_o(busy_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int x, input int y);
    drop_valid_i = 1'b1;
    drop_x_i     = 9'(x);
    drop_y_i     = 9'(y);
    tick();
    drop_valid_i = 1'b0;
  endtask

  task automatic preload(input int a, input int d);
    wr_en_i   = 1'b1;
    addr_i    = 5'(a);
    wr_data_i = HW'(d);
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic wait_idle(input bit both, input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      tick();
      if (stable_o && !busy_o && (!both || (stable_w && !busy_w))) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic read_cell(input int a, output int v_o, output int v_w);
    addr_i = 5'(a);
    tick();
    v_o = int'(rd_o);
    v_w = int'(rd_w);
  endtask

  task automatic sum_grid(output int s_o, output int s_w, output int max_o);
    int v_o, v_w;
    s_o = 0; s_w = 0; max_o = 0;
    for (int a = 0; a < ROWS*COLS; a++) begin
      read_cell(a, v_o, v_w);
      s_o += v_o;
      s_w += v_w;
      if (v_o > max_o) max_o = v_o;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_o, v_w, s_o, s_w, m_o;
    rst = 1'b1; run_i = 1'b0; clear_i = 1'b0; drop_valid_i = 1'b0; wr_en_i = 1'b0;
    rows_i = '0; cols_i = '0; drop_x_i = '0; drop_y_i = '0; addr_i = '0; wr_data_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_stable", stable_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_aval", aval_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_ready", ready_o, 1);

    // four drops on the centre of an empty grid
    run_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drop(2, 2);
      wait_idle(1, "centre_drop");
    end
    read_cell(12, v_o, v_w); check("centre_h", v_o, 0);
    read_cell(7,  v_o, v_w); check("north_h", v_o, 1);
    read_cell(11, v_o, v_w); check("west_h", v_o, 1);
    read_cell(13, v_o, v_w); check("east_h", v_o, 1);
    read_cell(17, v_o, v_w); check("south_h", v_o, 1);
    read_cell(6,  v_o, v_w); check("diag_h", v_o, 0);
    check("centre_aval", aval_o, 1);
    sum_grid(s_o, s_w, m_o);
    check("centre_sum", s_o, 4);

    // all cells at 3 plus one centre grain, open border
    run_i = 1'b0;
    do_clear();
    for (int a = 0; a < ROWS*COLS; a++) preload(a, 3);
    run_i = 1'b1;
    tick();
    drop(2, 2);
    wait_idle(0, "full_aval");
    check("full_stable", stable_o, 1);
    check("full_aval_nz", aval_o != 0, 1);
    sum_grid(s_o, s_w, m_o);
    check("full_sum_lt76", s_o < 76, 1);
    check("full_max_lt4", m_o < 4, 1);

    // corner topple, wrap vs open border
    run_i = 1'b0;
    do_clear();
    preload(0, 3);
    run_i = 1'b1;
    tick();
    drop(0, 0);
    wait_idle(1, "corner");
    read_cell(0,  v_o, v_w); check("wrap_00", v_w, 0);
    read_cell(1,  v_o, v_w); check("wrap_01", v_w, 1); check("open_01", v_o, 1);
    read_cell(5,  v_o, v_w); check("wrap_10", v_w, 1);
    read_cell(4,  v_o, v_w); check("wrap_04", v_w, 1); check("open_04", v_o, 0);
    read_cell(20, v_o, v_w); check("wrap_40", v_w, 1);
    check("wrap_aval", aval_w, 1);
    sum_grid(s_o, s_w, m_o);
    check("wrap_sum", s_w, 4);
    check("open_sum", s_o, 2);

    // shrunken window: out-of-window drop is rejected with a pulse
    do_clear();
    rows_i = 3'd3;
    drop(4, 4);
    check("err_pulse", err_o, 1);
    tick();
    check("err_clear", err_o, 0);
    drop(4, 2);
    check("err_inwin", err_o, 0);
    wait_idle(1, "window");
    read_cell(14, v_o, v_w); check("win_cell14", v_o, 1);
    sum_grid(s_o, s_w, m_o);
    check("win_sum", s_o, 1);

    // fill the FIFO while frozen, then let it drain
    run_i = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) drop(1, 1);
    check("fifo_full_ready", ready_o, 0);
    drop(1, 1);
    check("fifo_full_hold", ready_o, 0);
    run_i = 1'b1;
    wait_idle(1, "fifo_drain");
    read_cell(6,  v_o, v_w); check("fifo_cell6", v_o, 0);
    read_cell(11, v_o, v_w); check("fifo_cell11", v_o, 1);
    sum_grid(s_o, s_w, m_o);
    check("fifo_sum", s_o, 4);

    // preload attempt while busy is ignored
    rows_i = '0;
    run_i = 1'b0;
    do_clear();
    for (int i = 0; i < 3; i++) drop(0, 0);
    run_i = 1'b1;
    tick();
    tick();
    check("busy_in_drop", busy_o, 1);
    preload(24, 9);
    wait_idle(1, "busy_wr");
    read_cell(24, v_o, v_w); check("busy_wr_ignored", v_o, 0);
    read_cell(0,  v_o, v_w); check("busy_drops", v_o, 3);

    // readback latency and collapse flag
    run_i = 1'b0;
    tick();
    preload(12, 5);
    check("collapse_12", coll_o[12], 1);
    addr_i = 5'd24;
    tick();
    check("rd_addr24", rd_o, 0);
    addr_i = 5'd12;
    #1;
    check("rd_before_edge", rd_o, 0);
    tick();
    check("rd_after_edge", rd_o, 5);

    // asynchronous reset in the middle of an avalanche
    do_clear();
    for (int a = 0; a < ROWS*COLS; a++) preload(a, 3);
    run_i = 1'b1;
    tick();
    drop(2, 2);
    repeat (3) tick();
    check("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_stable", stable_o, 1);
    check("mid_rst_collapse", coll_o, 0);
    check("mid_rst_ready", ready_o, 1);
    tick();
    rst = 1'b0;
    sum_grid(s_o, s_w, m_o);
    check("rst_sum_open", s_o, 0);
    check("rst_sum_wrap", s_w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
